// File: rtl/alu_seq_pkg.sv
// Shared types for the registered ALU: opcode and FSM enums, reserved-op detection.
// Optional multiplier is enabled by defining ALU_SEQ_MUL_EN.
package alu_seq_pkg;

    typedef enum logic [3:0] {
        OP_ADD    = 4'd0,
        OP_SUB    = 4'd1,
        OP_AND    = 4'd2,
        OP_OR     = 4'd3,
        OP_NOT    = 4'd4,
        OP_XOR    = 4'd5,
        OP_PASSB  = 4'd6,
        OP_INC    = 4'd7,
        OP_SLL    = 4'd8,
        OP_SRL    = 4'd9,
        OP_SRA    = 4'd10,
        OP_SLT    = 4'd11,
        OP_MUL    = 4'd12,
        OP_SLTU   = 4'd13,
        OP_RSV14  = 4'd14,
        OP_RSV15  = 4'd15
    } op_t;

    typedef enum logic {
        IDLE = 1'b0,
        MUL  = 1'b1
    } state_t;

    localparam logic [3:0] OP_RSV_FIRST = 4'd14;

`ifdef ALU_SEQ_MUL_EN
    localparam bit MUL_EN = 1'b1;
`else
    localparam bit MUL_EN = 1'b0;
`endif

    // Without the multiplier, op 12 joins the reserved range.
    function automatic logic is_reserved(input logic [3:0] op);
        return (op >= OP_RSV_FIRST) || (!MUL_EN && (op == OP_MUL));
    endfunction

endpackage

// File: rtl/alu_seq_if.sv
// Operand/result handshake bundle for alu_seq; master drives operands, slave returns results.
interface alu_seq_if #(parameter int WIDTH = 8);

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [3:0]       op;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] y;
    logic             zero;
    logic             neg;
    logic             carry;
    logic             ovf;
    logic             err;

    modport master (
        output in_valid, a, b, op, out_ready,
        input  in_ready, out_valid, y, zero, neg, carry, ovf, err
    );

    modport slave (
        input  in_valid, a, b, op, out_ready,
        output in_ready, out_valid, y, zero, neg, carry, ovf, err
    );

endinterface

// File: rtl/alu_mul_seq.sv
// Unsigned shift-add multiplier: one bit of b per cycle, done pulses on the final iteration
// with the full 2*WIDTH product presented combinationally alongside it.
module alu_mul_seq #(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               done,
    output logic [2*WIDTH-1:0] product
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    logic               busy_q,   busy_d;
    logic [CW-1:0]      cnt_q,    cnt_d;
    logic [2*WIDTH-1:0] mcand_q,  mcand_d;
    logic [WIDTH-1:0]   mplier_q, mplier_d;
    logic [2*WIDTH-1:0] acc_q,    acc_d;
    logic [2*WIDTH-1:0] acc_next;

    assign acc_next = acc_q + (mplier_q[0] ? mcand_q : '0);
    assign done     = busy_q && (cnt_q == CNT_LAST);
    assign product  = acc_next;

    always_comb begin
        busy_d   = busy_q;
        cnt_d    = cnt_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        if (start) begin
            busy_d   = 1'b1;
            cnt_d    = '0;
            mcand_d  = {{WIDTH{1'b0}}, a};
            mplier_d = b;
            acc_d    = '0;
        end else if (busy_q) begin
            acc_d    = acc_next;
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q + CW'(1);
            if (done) begin
                busy_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q   <= 1'b0;
            cnt_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
        end else begin
            busy_q   <= busy_d;
            cnt_q    <= cnt_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
        end
    end

endmodule

// File: rtl/alu_seq.sv
// Registered ALU with valid/ready handshakes, shifts, compares and status flags.
// Define ALU_SEQ_MUL_EN to add the multi-cycle shift-add multiplier on op 12.
module alu_seq #(
    parameter int WIDTH = 8
) (
    input  logic      clk,
    input  logic      rst,
    alu_seq_if.slave  bus
);
    import alu_seq_pkg::*;

    localparam int              SHW     = $clog2(WIDTH);
    localparam int              MSB     = WIDTH - 1;
    localparam logic [WIDTH-1:0] WIDTH_V = WIDTH'(WIDTH);
    localparam logic [WIDTH-1:0] SMAX    = {1'b0, {(WIDTH-1){1'b1}}};

    state_t           state_q, state_d;
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] y_q, y_d;
    logic             zero_q, zero_d;
    logic             neg_q, neg_d;
    logic             carry_q, carry_d;
    logic             ovf_q, ovf_d;
    logic             err_q, err_d;

    logic             accept;
    logic [WIDTH:0]   sum_w, diff_w, inc_w, sll_w, srl_w;
    logic signed [WIDTH:0] sra_w;
    logic [SHW-1:0]   sh_amt;
    logic             sh_big;
    logic             lt_s, lt_u;

    logic [WIDTH-1:0] alu_y;
    logic             alu_c, alu_o, alu_e;

    logic             ld_en;
    logic [WIDTH-1:0] ld_y;
    logic             ld_c, ld_o, ld_e;

    assign bus.in_ready  = (state_q == IDLE) && (!out_valid_q || bus.out_ready);
    assign accept        = bus.in_valid && bus.in_ready;

    assign bus.out_valid = out_valid_q;
    assign bus.y         = y_q;
    assign bus.zero      = zero_q;
    assign bus.neg       = neg_q;
    assign bus.carry     = carry_q;
    assign bus.ovf       = ovf_q;
    assign bus.err       = err_q;

    // The extra MSB/LSB in these words catches the carry or the last bit shifted out.
    assign sum_w  = {1'b0, bus.a} + {1'b0, bus.b};
    assign diff_w = {1'b0, bus.a} - {1'b0, bus.b};
    assign inc_w  = {1'b0, bus.a} + (WIDTH+1)'(1);
    assign sh_amt = bus.b[SHW-1:0];
    assign sh_big = (bus.b >= WIDTH_V);
    assign sll_w  = {1'b0, bus.a} << sh_amt;
    assign srl_w  = {bus.a, 1'b0} >> sh_amt;
    assign sra_w  = $signed({bus.a, 1'b0}) >>> sh_amt;
    assign lt_s   = $signed(bus.a) < $signed(bus.b);
    assign lt_u   = bus.a < bus.b;

`ifdef ALU_SEQ_MUL_EN
    logic               mul_start;
    logic               mul_done;
    logic [2*WIDTH-1:0] mul_prod;

    assign mul_start = accept && (bus.op == OP_MUL);

    alu_mul_seq #(.WIDTH(WIDTH)) u_mul (
        .clk     (clk),
        .rst     (rst),
        .start   (mul_start),
        .a       (bus.a),
        .b       (bus.b),
        .done    (mul_done),
        .product (mul_prod)
    );
`endif

    // NOTE: every output of a combinational block gets a default first, so no path infers a latch.
    always_comb begin
        alu_y = '0;
        alu_c = 1'b0;
        alu_o = 1'b0;
        alu_e = is_reserved(bus.op);
        case (bus.op)
            OP_ADD: begin
                {alu_c, alu_y} = sum_w;
                alu_o = (bus.a[MSB] == bus.b[MSB]) && (sum_w[MSB] != bus.a[MSB]);
            end
            OP_SUB: begin
                {alu_c, alu_y} = diff_w;
                alu_o = (bus.a[MSB] != bus.b[MSB]) && (diff_w[MSB] != bus.a[MSB]);
            end
            OP_AND:   alu_y = bus.a & bus.b;
            OP_OR:    alu_y = bus.a | bus.b;
            OP_NOT:   alu_y = ~bus.a;
            OP_XOR:   alu_y = bus.a ^ bus.b;
            OP_PASSB: alu_y = bus.b;
            OP_INC: begin
                {alu_c, alu_y} = inc_w;
                alu_o = (bus.a == SMAX);
            end
            OP_SLL: begin
                if (!sh_big) {alu_c, alu_y} = sll_w;
            end
            OP_SRL: begin
                if (!sh_big) {alu_y, alu_c} = srl_w;
            end
            OP_SRA: begin
                if (sh_big) alu_y = {WIDTH{bus.a[MSB]}};
                else        {alu_y, alu_c} = sra_w;
            end
            OP_SLT:  alu_y = WIDTH'(lt_s);
            OP_SLTU: alu_y = WIDTH'(lt_u);
            default: ;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        out_valid_d = out_valid_q;
        y_d         = y_q;
        zero_d      = zero_q;
        neg_d       = neg_q;
        carry_d     = carry_q;
        ovf_d       = ovf_q;
        err_d       = err_q;
        ld_en       = 1'b0;
        ld_y        = alu_y;
        ld_c        = alu_c;
        ld_o        = alu_o;
        ld_e        = alu_e;

        if (accept) begin
`ifdef ALU_SEQ_MUL_EN
            if (bus.op == OP_MUL) begin
                // The old result was consumed this edge (in_ready demands it), so clear it.
                state_d     = MUL;
                out_valid_d = 1'b0;
                y_d         = '0;
                zero_d      = 1'b0;
                neg_d       = 1'b0;
                carry_d     = 1'b0;
                ovf_d       = 1'b0;
                err_d       = 1'b0;
            end else
`endif
            begin
                out_valid_d = 1'b1;
                ld_en       = 1'b1;
            end
        end else if (out_valid_q && bus.out_ready) begin
            out_valid_d = 1'b0;
        end

`ifdef ALU_SEQ_MUL_EN
        if ((state_q == MUL) && mul_done) begin
            state_d     = IDLE;
            out_valid_d = 1'b1;
            ld_en       = 1'b1;
            ld_y        = mul_prod[WIDTH-1:0];
            ld_c        = |mul_prod[2*WIDTH-1:WIDTH];
            ld_o        = 1'b0;
            ld_e        = 1'b0;
        end
`endif

        if (ld_en) begin
            y_d     = ld_y;
            zero_d  = (ld_y == '0);
            neg_d   = ld_y[MSB];
            carry_d = ld_c;
            ovf_d   = ld_o;
            err_d   = ld_e;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
            y_q         <= '0;
            zero_q      <= 1'b0;
            neg_q       <= 1'b0;
            carry_q     <= 1'b0;
            ovf_q       <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            out_valid_q <= out_valid_d;
            y_q         <= y_d;
            zero_q      <= zero_d;
            neg_q       <= neg_d;
            carry_q     <= carry_d;
            ovf_q       <= ovf_d;
            err_q       <= err_d;
        end
    end

endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
- Parametrised, registered ALU; next generation of the team's 4-bit combinational ALU.
- Adds configurable WIDTH, a 4-bit opcode with shifts and compares, status flags, and an optional multi-cycle shift-add multiplier.
- Uses valid/ready handshakes on both sides so it can sit inside pipelined datapaths with backpressure.

Parameters:
- WIDTH, 8, operand and result width in bits; must be >= 2.
- SHW, $clog2(WIDTH), derived; width of the shift-amount field.

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  operand/opcode valid.
- in_ready  output  1  block can accept a new operation.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B, or the shift amount for shift ops.
- op  input  4  operation select.
- out_valid  output  1  y and flags valid.
- out_ready  input  1  consumer accepts the result.
- y  output  WIDTH  result.
- zero  output  1  y == 0.
- neg  output  1  y[WIDTH-1].
- carry  output  1  carry/borrow/shift-out/multiply-high flag.
- ovf  output  1  signed overflow.
- err  output  1  reserved opcode was issued.

Behaviour:
- Reset (rst=1 at a clk edge):
  - state=IDLE; out_valid, y, zero, neg, carry, ovf and err all 0.
  - rst has priority over every other event.
  - Reset mid-multiply aborts it; no result is produced.
- in_ready = (state==IDLE) && (!out_valid || out_ready).
- Accept: in_valid && in_ready at an edge.
- Result hand-off: out_valid && out_ready at an edge. If a new op is accepted in the same cycle, its single-cycle result replaces the old one and out_valid stays 1; otherwise out_valid goes to 0.
- While out_valid=1 && out_ready=0, y and all flags hold stable.
- Single-cycle ops: y and flags registered on the accept edge; out_valid=1 the next cycle (latency 1).
- Opcodes; all arithmetic is modulo 2^WIDTH:
  - 0 ADD, a+b: carry = carry-out; ovf = signed overflow.
  - 1 SUB, a-b: carry = borrow (a<b unsigned); ovf = signed overflow.
  - 2 AND.
  - 3 OR.
  - 4 NOT A, ~a.
  - 5 XOR.
  - 6 PASS B, y=b.
  - 7 INC A, a+1: carry = carry-out; ovf set when a == 0111..1.
  - 8 SLL, a << b.
  - 9 SRL, a >> b.
  - 10 SRA, arithmetic shift right.
  - 11 SLT, y = ($signed(a) < $signed(b)) ? 1 : 0.
  - 12 MUL, see optional feature.
  - 13 SLTU, unsigned compare, same result encoding as SLT.
  - 14, 15 reserved: y=0, err=1, zero=1; other flags 0.
- err is 0 for every valid opcode.
- Shift rules:
  - Shift amount is the full b value.
  - b == 0: y=a, carry=0.
  - b >= WIDTH: SLL/SRL give y=0, SRA gives all sign bits; carry=0.
  - Otherwise carry = last bit shifted out.
- ovf=0 and carry=0 for every op not listed above as setting them.
- zero and neg are always derived from the registered y.

State machine:
- States: IDLE, MUL.
- IDLE -> MUL: MUL accepted.
- MUL -> IDLE: after WIDTH iterations.
- in_ready=0 throughout MUL.

Optional Feature:
- Macro: ALU_SEQ_MUL_EN.
- Defined:
  - op 12 runs an unsigned shift-add multiply, one bit of b per cycle, WIDTH cycles in MUL.
  - Result and out_valid are registered on the WIDTH-th MUL edge, giving latency WIDTH+1 cycles from the accept edge.
  - y = product[WIDTH-1:0]; carry = |product[2*WIDTH-1:WIDTH]; ovf=0.
  - out_valid and the previous result are cleared on entry to MUL once that result has been consumed (the in_ready condition guarantees this).
- Not defined:
  - op 12 is treated as reserved (err=1, y=0, latency 1).
  - The MUL state and multiplier logic are absent.

Decomposition:
- Package alu_seq_pkg:
  - op_t enum with the 16 opcode names.
  - state_t enum (IDLE, MUL).
  - Localparams for reserved-op detection.
- One natural sub-module: alu_mul_seq. It is a shift-add multiplier with start/done and a WIDTH-wide operand pair, instantiated only under ALU_SEQ_MUL_EN.

Test Plan (all at WIDTH=8):
- ADD a=0xFF, b=0x01, out_ready=1 -> next cycle y=0x00, zero=1, carry=1, ovf=0, out_valid=1.
- SUB a=0x80, b=0x01 -> y=0x7F, ovf=1, carry=0; SUB a=0x01, b=0x02 -> y=0xFF, carry=1, neg=1.
- SRA a=0x90, b=3 -> y=0xF2, carry=0; SRA a=0x90, b=9 -> y=0xFF; SLL a=0x81, b=1 -> y=0x02, carry=1.
- Backpressure: out_ready=0, issue AND then XOR -> in_ready=0 after the first op, y holds the AND result; raise out_ready -> XOR accepted in the hand-off cycle, y updates on the next cycle.
- op=14 -> err=1, y=0, zero=1. With ALU_SEQ_MUL_EN, MUL a=0x10, b=0x20 -> out_valid after 9 cycles, y=0x00, carry=1, in_ready=0 throughout.
- Reset mid-MUL (rst at cycle 4 of MUL) -> next cycle state=IDLE, out_valid=0, all outputs 0, in_ready=1.
